// File: rtl/phased_cache_pkg.sv
// Shared constants, FSM state type and way-select helpers for the phased cache.
package phased_cache_pkg;

  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 4;
  localparam int INDEX_W  = 6;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WAYS     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CMP  = 2'd2,
    RESP = 2'd3
  } state_t;

  // Isolates the lowest set bit, so the result is one-hot or zero.
  function automatic logic [7:0] lowest_onehot(input logic [7:0] v);
    return v & (~v + 8'd1);
  endfunction

  function automatic logic more_than_one(input logic [7:0] v);
    return |(v & (v - 8'd1));
  endfunction

endpackage

// File: rtl/tag_way_compare.sv
// Parallel tag comparators with valid gating; one match bit per way.
module tag_way_compare #(
  parameter int TAG_W = 22,
  parameter int WAYS  = 8
) (
  input  logic [WAYS*TAG_W-1:0] tags,
  input  logic [WAYS-1:0]       vbits,
  input  logic [TAG_W-1:0]      tag,
  output logic [WAYS-1:0]       match
);

  always_comb begin
    match = '0;
    for (int w = 0; w < WAYS; w++) begin
      match[w] = vbits[w] && (tags[w*TAG_W +: TAG_W] == tag);
    end
  end

endmodule

// File: rtl/phased_tag_lookup.sv
// Tag phase of the phased cache: one lookup in flight, reads the tag row,
// compares all ways and holds a registered one-hot hit vector until consumed.
module phased_tag_lookup
  import phased_cache_pkg::state_t, phased_cache_pkg::IDLE, phased_cache_pkg::RD,
         phased_cache_pkg::CMP, phased_cache_pkg::RESP,
         phased_cache_pkg::lowest_onehot, phased_cache_pkg::more_than_one;
#(
  parameter int ADDR_W   = phased_cache_pkg::ADDR_W,
  parameter int OFFSET_W = phased_cache_pkg::OFFSET_W,
  parameter int INDEX_W  = phased_cache_pkg::INDEX_W,
  parameter int WAYS     = phased_cache_pkg::WAYS,
  localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  output logic                  tag_rd_en,
  output logic [INDEX_W-1:0]    tag_rd_index,
  input  logic [WAYS*TAG_W-1:0] tag_rd_tags,
  input  logic [WAYS-1:0]       tag_rd_vbits,
  output logic                  hit_valid,
  input  logic                  hit_ready,
  output logic [WAYS-1:0]       hit_way,
  output logic                  hit,
  output logic                  multi_hit,
  output logic                  err_multi_hit,
  output logic [INDEX_W-1:0]    hit_index,
  output logic [TAG_W-1:0]      hit_tag,
  output state_t                dbg_state
);

  if (WAYS != 8) begin : g_ways_check
    $error("phased_tag_lookup: WAYS must be 8 to feed the 8-to-3 way encoder");
  end

  state_t             state_q, state_d;
  logic [INDEX_W-1:0] idx_q, idx_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [WAYS-1:0]    hit_way_q, hit_way_d;
  logic               hit_q, hit_d;
  logic               multi_q, multi_d;
  logic               err_q, err_d;
  logic [WAYS-1:0]    match;
  logic               unused_offset;

  assign unused_offset = ^req_addr[OFFSET_W-1:0];

  // Compare against the captured tag only, so RAM bus noise never reaches a flop.
  tag_way_compare #(
    .TAG_W (TAG_W),
    .WAYS  (WAYS)
  ) u_tag_way_compare (
    .tags  (tag_rd_tags),
    .vbits (tag_rd_vbits),
    .tag   (tag_q),
    .match (match)
  );

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and all handshake outputs here are
  // pure decodes of the registered state, never combinational on inputs.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tag_d     = tag_q;
    hit_way_d = hit_way_q;
    hit_d     = hit_q;
    multi_d   = multi_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          idx_d   = req_addr[OFFSET_W +: INDEX_W];
          tag_d   = req_addr[ADDR_W-1 -: TAG_W];
          state_d = RD;
        end
      end
      RD: begin
        state_d = CMP;
      end
      CMP: begin
        hit_way_d = lowest_onehot(match);
        hit_d     = |match;
        multi_d   = more_than_one(match);
        err_d     = err_q | multi_d;
        state_d   = RESP;
      end
      RESP: begin
        if (hit_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      tag_q     <= '0;
      hit_way_q <= '0;
      hit_q     <= 1'b0;
      multi_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tag_q     <= tag_d;
      hit_way_q <= hit_way_d;
      hit_q     <= hit_d;
      multi_q   <= multi_d;
      err_q     <= err_d;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign tag_rd_en     = (state_q == RD);
  assign tag_rd_index  = idx_q;
  assign hit_valid     = (state_q == RESP);
  assign hit_way       = hit_way_q;
  assign hit           = hit_q;
  assign multi_hit     = multi_q;
  assign err_multi_hit = err_q;
  assign hit_index     = idx_q;
  assign hit_tag       = tag_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_phased_tag_lookup.sv
// Bench for phased_tag_lookup: RAM model, random and directed lookups,
// scoreboard queue with an independent monitor.
module tb_phased_tag_lookup;
  import phased_cache_pkg::*;

  typedef struct {
    logic [WAYS-1:0]    way;
    logic               hit;
    logic               multi;
    logic               err;
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     req_addr;
  logic                  tag_rd_en;
  logic [INDEX_W-1:0]    tag_rd_index;
  logic [WAYS*TAG_W-1:0] tag_rd_tags;
  logic [WAYS-1:0]       tag_rd_vbits;
  logic                  hit_valid;
  logic                  hit_ready;
  logic [WAYS-1:0]       hit_way;
  logic                  hit;
  logic                  multi_hit;
  logic                  err_multi_hit;
  logic [INDEX_W-1:0]    hit_index;
  logic [TAG_W-1:0]      hit_tag;
  state_t                dbg_state;

  phased_tag_lookup dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .tag_rd_en     (tag_rd_en),
    .tag_rd_index  (tag_rd_index),
    .tag_rd_tags   (tag_rd_tags),
    .tag_rd_vbits  (tag_rd_vbits),
    .hit_valid     (hit_valid),
    .hit_ready     (hit_ready),
    .hit_way       (hit_way),
    .hit           (hit),
    .multi_hit     (multi_hit),
    .err_multi_hit (err_multi_hit),
    .hit_index     (hit_index),
    .hit_tag       (hit_tag),
    .dbg_state     (dbg_state)
  );

  // ---------------- state ----------------
  logic [TAG_W-1:0] mem_tag [64][WAYS];
  logic             mem_v   [64][WAYS];
  exp_t   exp_q[$];
  int     acc_q[$];
  int     n_checks = 0;
  int     n_pass = 0;
  int     cyc = 0;
  int     hr_mode = 1;
  bit     err_model = 0;
  bit     b2b = 0;
  int     last_acc = -1;
  bit     prev_hv = 0;
  bit     post_chk = 0;
  longint snap;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous tag RAM: row appears the cycle after the read strobe, noise otherwise.
  always @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (tag_rd_en) begin
        tag_rd_tags[w*TAG_W +: TAG_W] <= mem_tag[tag_rd_index][w];
        tag_rd_vbits[w]               <= mem_v[tag_rd_index][w];
      end else begin
        tag_rd_tags[w*TAG_W +: TAG_W] <= TAG_W'($urandom);
        tag_rd_vbits[w]               <= 1'($urandom);
      end
    end
  end

  // hit_ready: 0 = random, 1 = always ready, 2 = stalled
  always @(posedge clk) begin
    #1;
    if (hr_mode == 0)      hit_ready = 1'($urandom_range(0, 1));
    else if (hr_mode == 1) hit_ready = 1'b1;
    else                   hit_ready = 1'b0;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  task automatic check_reset_vals(input string tag_s);
    chk({tag_s, "_req_ready"}, req_ready, 1);
    chk({tag_s, "_tag_rd_en"}, tag_rd_en, 0);
    chk({tag_s, "_hit_valid"}, hit_valid, 0);
    chk({tag_s, "_hit_way"}, hit_way, 0);
    chk({tag_s, "_hit"}, hit, 0);
    chk({tag_s, "_multi_hit"}, multi_hit, 0);
    chk({tag_s, "_err_multi_hit"}, err_multi_hit, 0);
    chk({tag_s, "_hit_index"}, hit_index, 0);
    chk({tag_s, "_hit_tag"}, hit_tag, 0);
  endtask

  // Reference: address split by arithmetic, then count matching valid ways.
  function automatic exp_t model(input logic [ADDR_W-1:0] addr);
    exp_t e;
    int   idx;
    int   cnt;
    logic [ADDR_W-1:0] t;
    idx = int'((addr / 16) % 64);
    t   = addr / 1024;
    e.idx = idx[INDEX_W-1:0];
    e.tag = t[TAG_W-1:0];
    e.way = '0;
    cnt = 0;
    for (int w = 0; w < WAYS; w++) begin
      if (mem_v[idx][w] && mem_tag[idx][w] == e.tag) begin
        cnt++;
        if (cnt == 1) e.way[w] = 1'b1;
      end
    end
    e.hit   = (cnt > 0);
    e.multi = (cnt > 1);
    e.err   = 1'b0;
    return e;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hv  = 0;
      post_chk = 0;
    end else begin
      if (req_valid && req_ready) begin
        acc_q.push_back(cyc);
        if (b2b && last_acc >= 0) chk("accept_spacing", cyc - last_acc, 4);
        last_acc = cyc;
      end
      if (tag_rd_en) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) fail_now("rd_without_request");
        else begin
          chk("rd_index", tag_rd_index, exp_q[0].idx);
          chk("rd_latency", cyc - acc_q[0], 1);
        end
      end
      if (hit_valid) begin
        chk("req_ready_in_resp", req_ready, 0);
        if (!prev_hv) begin
          if (exp_q.size() == 0 || acc_q.size() == 0) fail_now("unexpected_result");
          else begin
            chk("hit_latency", cyc - acc_q.pop_front(), 3);
            chk("hit_way", hit_way, exp_q[0].way);
            chk("hit", hit, exp_q[0].hit);
            chk("multi_hit", multi_hit, exp_q[0].multi);
            chk("err_multi_hit", err_multi_hit, exp_q[0].err);
            chk("hit_index", hit_index, exp_q[0].idx);
            chk("hit_tag", hit_tag, exp_q[0].tag);
          end
          snap = {hit_way, hit, multi_hit, err_multi_hit, hit_index, hit_tag};
        end else begin
          chk("resp_stable", {hit_way, hit, multi_hit, err_multi_hit, hit_index, hit_tag}, snap);
        end
        if (hit_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          post_chk = 1;
        end
      end else if (post_chk) begin
        chk("ready_after_resp", req_ready, 1);
        post_chk = 0;
      end
      prev_hv = hit_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic [ADDR_W-1:0] addr);
    exp_t e;
    bit   ok;
    ok = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = addr;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) begin
        e = model(addr);
        err_model = err_model | e.multi;
        e.err = err_model;
        exp_q.push_back(e);
        ok = 1;
      end
    end
    if (!ok) fail_now("req_accept");
  endtask

  task automatic drop_req();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (req_ready && exp_q.size() == 0) ok = 1;
    end
    if (!ok) fail_now("idle_wait");
  endtask

  task automatic set_row(input int idx, input logic [TAG_W-1:0] t0, input logic [TAG_W-1:0] t,
                         input logic [WAYS-1:0] tag_sel, input logic [WAYS-1:0] v);
    for (int w = 0; w < WAYS; w++) begin
      mem_tag[idx][w] = tag_sel[w] ? t : t0;
      mem_v[idx][w]   = v[w];
    end
  endtask

  task automatic rand_row(input int idx, input logic [TAG_W-1:0] t);
    for (int w = 0; w < WAYS; w++) begin
      mem_tag[idx][w] = ($urandom_range(0, 2) == 0) ? t : TAG_W'($urandom);
      mem_v[idx][w]   = 1'($urandom_range(0, 1));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] tt;
    bit ok;
    req_valid = 1'b0;
    req_addr  = '0;
    hit_ready = 1'b0;
    for (int i = 0; i < 64; i++) set_row(i, '0, '0, '0, '0);

    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // single hit in way 5
    hr_mode = 1;
    set_row(8'h23, 22'h0, 22'h4, 8'b0010_0000, 8'hFF);
    do_req(32'h0000_1230);
    drop_req();
    wait_idle();

    // matching tag but invalid way 2 -> miss
    set_row(8'h23, 22'h9, 22'h4, 8'b0000_0100, 8'b1111_1011);
    do_req(32'h0000_1230);
    drop_req();
    wait_idle();

    // multi-hit in ways 3 and 6, then a clean hit keeps the sticky error
    set_row(8'h23, 22'h0, 22'h4, 8'b0100_1000, 8'hFF);
    do_req(32'h0000_1230);
    drop_req();
    wait_idle();
    set_row(8'h23, 22'h0, 22'h4, 8'b0010_0000, 8'hFF);
    do_req(32'h0000_1230);
    drop_req();
    wait_idle();

    // backpressure: stall RESP while the RAM bus keeps changing
    hr_mode = 2;
    do_req(32'h0000_1230);
    drop_req();
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (hit_valid) ok = 1;
    end
    if (!ok) fail_now("bp_result");
    repeat (5) @(negedge clk);
    hr_mode = 1;
    wait_idle();

    // random lookups with random downstream readiness
    hr_mode = 0;
    for (int n = 0; n < 40; n++) begin
      a  = $urandom;
      tt = a / 1024;
      rand_row(int'((a / 16) % 64), tt[TAG_W-1:0]);
      do_req(a);
      drop_req();
      wait_idle();
    end

    // back-to-back with zero-wait consumer
    hr_mode = 1;
    for (int n = 0; n < 6; n++) rand_row(n * 7 + 1, TAG_W'(n + 100));
    b2b = 1;
    last_acc = -1;
    for (int n = 0; n < 6; n++) begin
      a = (32'(n + 100) << 10) | (32'(n * 7 + 1) << 4) | 32'($urandom_range(0, 15));
      do_req(a);
    end
    drop_req();
    wait_idle();
    b2b = 0;

    // asynchronous reset while in CMP
    set_row(8'h23, 22'h0, 22'h4, 8'b0100_1000, 8'hFF);
    do_req(32'h0000_1230);
    drop_req();
    @(posedge clk);
    #3;
    chk("state_before_reset", dbg_state, CMP);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    exp_q.delete();
    acc_q.delete();
    err_model = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_reset_no_result", hit_valid, 0);
      chk("post_reset_ready", req_ready, 1);
    end

    // clean hit after reset: sticky error must be gone
    set_row(8'h23, 22'h0, 22'h4, 8'b0010_0000, 8'hFF);
    do_req(32'h0000_1230);
    drop_req();
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/phased_tag_lookup.md
Name: phased_tag_lookup

Overview:
- Tag phase of the phased cache. Accepts one lookup address and reads the 8-way tag/valid row for its index from the external tag RAM.
- Compares all 8 ways in parallel and presents a registered one-hot way-hit vector.
- That vector is the input of the downstream 8-to-3 way encoder that addresses the data phase.
- Non-pipelined, one request in flight; valid/ready on both sides.

Parameters:
- ADDR_W, 32, request address width.
- OFFSET_W, 4, line-offset bits (16-byte lines).
- INDEX_W, 6, set-index bits (64 sets).
- TAG_W, ADDR_W-INDEX_W-OFFSET_W (22), derived local parameter; do not override.
- WAYS, 8, fixed; downstream encoder is 8-to-3. Any other value is an elaboration error.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  lookup request valid.
- req_ready  out  1  block can accept a request.
- req_addr  in  ADDR_W  byte address.
- tag_rd_en  out  1  tag RAM read strobe.
- tag_rd_index  out  INDEX_W  tag RAM row.
- tag_rd_tags  in  WAYS*TAG_W  row tags; way w at bits [w*TAG_W +: TAG_W]. Sync RAM, valid the cycle after tag_rd_en.
- tag_rd_vbits  in  WAYS  per-way valid bits, same timing as tag_rd_tags.
- hit_valid  out  1  result valid.
- hit_ready  in  1  downstream accepts result.
- hit_way  out  WAYS  one-hot hit vector; all zero on miss.
- hit  out  1  OR of raw match vector.
- multi_hit  out  1  more than one way matched for this result.
- err_multi_hit  out  1  sticky multi-hit flag.
- hit_index  out  INDEX_W  index of the result.
- hit_tag  out  TAG_W  tag of the result (refill tag on miss).

Behaviour:
- Clocking and reset: single clock domain. rst_n is asynchronous assert, synchronous deassert externally.
- Reset values: state=IDLE; req_ready=1; tag_rd_en=0; hit_valid=0; hit_way=0; hit=0; multi_hit=0; err_multi_hit=0; hit_index=0; hit_tag=0.
- IDLE: req_ready=1. On req_valid&&req_ready, capture index=req_addr[OFFSET_W+:INDEX_W] and tag=req_addr[ADDR_W-1-:TAG_W]; go to RD.
- RD: req_ready=0; tag_rd_en=1 for exactly this cycle; tag_rd_index=captured index; go to CMP.
- CMP: per-way match m[w] = tag_rd_vbits[w] && (tag_rd_tags[w]==tag).
  - Register hit_way = lowest set bit of m (priority, so the output is always one-hot or zero).
  - Register hit = |m and multi_hit = (popcount(m)>1).
  - Set err_multi_hit if multi_hit.
  - Go to RESP.
- RESP: hit_valid=1; all result outputs held stable until hit_ready. On hit_valid&&hit_ready, go to IDLE with hit_valid=0 next cycle.
- Latency: accept at cycle N gives hit_valid at N+3. Minimum spacing between accepts is 4 cycles (zero-wait hit_ready).
- req_ready is a registered state decode, never combinational on hit_ready. A request presented in the cycle a result is consumed is accepted one cycle later.
- tag_rd_tags/vbits are sampled only in CMP; values in other cycles are ignored.
- Entry with vbit=0 and a matching tag does not hit.
- All ways invalid: hit_way=0, hit=0.
- Reset mid-operation, any state: immediate return to reset values. The pending request is dropped, no result is emitted, err_multi_hit clears.
- No X propagation: the compare uses registered tag only; outputs change only at state transitions.

Decomposition:
- Shared package phased_cache_pkg holds:
  - constants ADDR_W, OFFSET_W, INDEX_W, TAG_W, WAYS;
  - state enum {IDLE, RD, CMP, RESP};
  - function lowest_onehot(8-bit) -> 8-bit.
- One natural sub-module: tag_way_compare. Purely combinational: 8 comparators plus valid gating, producing m[7:0]. Instantiated once in the CMP datapath.

Test Plan:
- Reset then single hit: addr=0x0000_1230 (index 0x23, tag 0x4); RAM row way5 tag=0x4, vbit=1, others tag=0x0.
  - Expect tag_rd_en at cycle N+1 with tag_rd_index=0x23.
  - Expect at N+3: hit_valid=1, hit_way=8'b0010_0000, hit=1, multi_hit=0, hit_tag=0x4.
- Miss and invalid match: same addr; way2 tag=0x4 with vbit=0, all others mismatch.
  - Expect hit_way=0, hit=0, hit_tag=0x4.
- Multi-hit: ways 3 and 6 both tag=0x4, vbit=1.
  - Expect hit_way=8'b0000_1000, hit=1, multi_hit=1.
  - err_multi_hit stays 1 across the next clean hit until rst_n low.
- Backpressure: hold hit_ready=0 for 5 cycles in RESP while changing tag_rd_tags.
  - Expect outputs stable and req_ready=0.
  - Raise hit_ready: hit_valid drops next cycle, req_ready=1 next cycle.
- Back-to-back: req_valid held with hit_ready=1 throughout.
  - Expect accepts exactly every 4 cycles and results in order.
- Reset in CMP: drive rst_n=0 asynchronously mid-cycle.
  - Expect all outputs at reset values before the next clk edge.
  - After release: no hit_valid emitted; req_ready=1.
